// File: rtl/traffic_ctrl_multi_if.sv
// ============================================================================
// Module      : traffic_ctrl_multi_if
// Description : Control and status bundle of the two-road intersection
//               controller (enable/flash/pedestrian in, lamps/countdown out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_ctrl_multi_if;
   logic       i_en;
   logic       i_flash;
   logic       i_ped_req;
   logic [2:0] o_ns_light;
   logic [2:0] o_ew_light;
   logic [2:0] o_state;
   logic [6:0] o_remain;
   logic [7:0] o_remain_bcd;
   logic       o_tick;
   logic       o_ped_ack;

   modport slave (
      input  i_en, i_flash, i_ped_req,
      output o_ns_light, o_ew_light, o_state, o_remain, o_remain_bcd,
             o_tick, o_ped_ack
   );

   modport master (
      output i_en, i_flash, i_ped_req,
      input  o_ns_light, o_ew_light, o_state, o_remain, o_remain_bcd,
             o_tick, o_ped_ack
   );
endinterface

`default_nettype wire

// File: rtl/traffic_ctrl_multi.sv
// ============================================================================
// Module      : traffic_ctrl_multi
// Description : Six-phase NS/EW intersection controller with all-red
//               clearance, pedestrian green shortening and night flash mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_ctrl_multi #(
   parameter int F_CLK     = 50_000_000,
   parameter int F_TICK    = 1,
   parameter int T_GREEN   = 30,
   parameter int T_YELLOW  = 5,
   parameter int T_ALLRED  = 2,
   parameter int T_PED_MIN = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   traffic_ctrl_multi_if.slave  bus
);

   localparam int DIV = F_CLK / F_TICK;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0] c_PCNT_MAX  = PW'(DIV - 1);
   localparam logic [6:0]    c_T_GREEN   = 7'(T_GREEN);
   localparam logic [6:0]    c_T_YELLOW  = 7'(T_YELLOW);
   localparam logic [6:0]    c_T_ALLRED  = 7'(T_ALLRED);
   localparam logic [6:0]    c_T_PED_MIN = 7'(T_PED_MIN);

   localparam logic [2:0] c_NS_G  = 3'd0;
   localparam logic [2:0] c_NS_Y  = 3'd1;
   localparam logic [2:0] c_AR1   = 3'd2;
   localparam logic [2:0] c_EW_G  = 3'd3;
   localparam logic [2:0] c_EW_Y  = 3'd4;
   localparam logic [2:0] c_AR2   = 3'd5;
   localparam logic [2:0] c_FLASH = 3'd6;

   generate
      if (DIV < 2 || T_GREEN < 1 || T_GREEN > 99 || T_YELLOW < 1 || T_YELLOW > 99 ||
          T_ALLRED < 1 || T_ALLRED > 99 || T_PED_MIN < 1 || T_PED_MIN > T_GREEN - 1) begin : g_param_err
         $error("traffic_ctrl_multi: parameter out of range");
      end
   endgenerate

   function automatic logic [6:0] phase_dur(input logic [2:0] s);
      case (s)
         c_NS_G, c_EW_G: phase_dur = c_T_GREEN;
         c_NS_Y, c_EW_Y: phase_dur = c_T_YELLOW;
         default:        phase_dur = c_T_ALLRED;
      endcase
   endfunction

   // Returns {NS, EW} lamps, each {R,Y,G}.
   function automatic logic [5:0] lamps(input logic [2:0] s, input logic f);
      case (s)
         c_NS_G:  lamps = {3'b001, 3'b100};
         c_NS_Y:  lamps = {3'b010, 3'b100};
         c_EW_G:  lamps = {3'b100, 3'b001};
         c_EW_Y:  lamps = {3'b100, 3'b010};
         c_FLASH: lamps = {1'b0, f, 1'b0, 1'b0, f, 1'b0};
         default: lamps = {3'b100, 3'b100};
      endcase
   endfunction

   logic [2:0]    state_q, state_d;
   logic [6:0]    remain_q, remain_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          f_q, f_d;
   logic          tick_q, tick_d;
   logic          ack_q, ack_d;
   logic [5:0]    lamp_q;
   logic          w_wrap;
   logic          w_green;

   assign w_wrap  = (pcnt_q == c_PCNT_MAX);
   assign w_green = (state_q == c_NS_G) || (state_q == c_EW_G);

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      pcnt_d   = pcnt_q;
      f_d      = f_q;
      tick_d   = 1'b0;
      ack_d    = 1'b0;
      if (bus.i_en) begin
         pcnt_d = w_wrap ? '0 : pcnt_q + 1'b1;
         tick_d = w_wrap;
         if (bus.i_flash) begin
            if (state_q != c_FLASH) begin
               state_d  = c_FLASH;
               f_d      = 1'b1;
               remain_d = 7'd0;
            end else if (w_wrap) begin
               f_d = ~f_q;
            end
         end else if (state_q == c_FLASH) begin
            state_d  = c_AR2;
            remain_d = c_T_ALLRED;
         end else begin
            ack_d = bus.i_ped_req && w_green;
            // Shortening overrides a coincident tick; an ack without shortening leaves the countdown alone.
            if (bus.i_ped_req && w_green && (remain_q > c_T_PED_MIN)) begin
               remain_d = c_T_PED_MIN;
            end else if (w_wrap) begin
               if (remain_q > 7'd1) begin
                  remain_d = remain_q - 7'd1;
               end else begin
                  state_d  = (state_q == c_AR2) ? c_NS_G : state_q + 3'd1;
                  remain_d = phase_dur(state_d);
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= c_NS_G;
         remain_q <= c_T_GREEN;
         pcnt_q   <= '0;
         f_q      <= 1'b1;
         tick_q   <= 1'b0;
         ack_q    <= 1'b0;
         lamp_q   <= {3'b001, 3'b100};
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         pcnt_q   <= pcnt_d;
         f_q      <= f_d;
         tick_q   <= tick_d;
         ack_q    <= ack_d;
         lamp_q   <= lamps(state_d, f_d);
      end
   end

   assign bus.o_state      = state_q;
   assign bus.o_remain     = remain_q;
   assign bus.o_ns_light   = lamp_q[5:3];
   assign bus.o_ew_light   = lamp_q[2:0];
   assign bus.o_tick       = tick_q;
   assign bus.o_ped_ack    = ack_q;
   assign bus.o_remain_bcd = {4'(remain_q / 7'd10), 4'(remain_q % 7'd10)};

endmodule

`default_nettype wire

// File: tb/tb_traffic_ctrl_multi.sv
// ============================================================================
// Module      : tb_traffic_ctrl_multi
// Description : Vector table, phase-dwell sequence and randomized run of
//               traffic_ctrl_multi against a phase-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_ctrl_multi;
   localparam int DIV = 10;
   localparam int TG  = 6;
   localparam int TY  = 2;
   localparam int TA  = 1;
   localparam int TP  = 2;

   typedef struct {
      bit         rst, en, fl, ped;
      int         n;
      int         st, rem;
      logic [2:0] ns, ew;
      bit         tk, ak;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   traffic_ctrl_multi_if bus();

   traffic_ctrl_multi #(
      .F_CLK(10), .F_TICK(1), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_PED_MIN(TP)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Phase-level reference: phase index, ticks left, cycles into the current second.
   int m_ph, m_rem, m_cyc;
   bit m_f, m_tick, m_ack;
   int         dur[6]    = '{TG, TY, TA, TG, TY, TA};
   logic [2:0] ns_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
   logic [2:0] ew_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

   function automatic logic [7:0] to_bcd(input int v);
      int t = 0;
      while (v >= 10) begin
         v -= 10;
         t++;
      end
      return {4'(t), 4'(v)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit sec_end;
      m_tick = 0;
      m_ack  = 0;
      if (rst) begin
         m_ph = 0; m_rem = TG; m_cyc = 0; m_f = 1;
      end else if (bus.i_en) begin
         sec_end = (m_cyc == DIV - 1);
         m_cyc   = (m_cyc + 1) % DIV;
         m_tick  = sec_end;
         if (bus.i_flash) begin
            if (m_ph != 6) begin
               m_ph = 6; m_f = 1; m_rem = 0;
            end else if (sec_end) begin
               m_f = !m_f;
            end
         end else if (m_ph == 6) begin
            m_ph = 5; m_rem = TA;
         end else begin
            if (bus.i_ped_req && (m_ph == 0 || m_ph == 3)) m_ack = 1;
            if (m_ack && m_rem > TP) m_rem = TP;
            else if (sec_end) begin
               if (m_rem > 1) m_rem--;
               else begin
                  m_ph  = (m_ph + 1) % 6;
                  m_rem = dur[m_ph];
               end
            end
         end
      end
   endtask

   task automatic compare_model();
      logic [2:0] ens, eew;
      ens = (m_ph == 6) ? {1'b0, m_f, 1'b0} : ns_tab[m_ph];
      eew = (m_ph == 6) ? {1'b0, m_f, 1'b0} : ew_tab[m_ph];
      chk("model_state", 32'(bus.o_state), 32'(m_ph));
      chk("model_remain", 32'(bus.o_remain), 32'(m_rem));
      chk("model_bcd", 32'(bus.o_remain_bcd), 32'(to_bcd(m_rem)));
      chk("model_ns", 32'(bus.o_ns_light), 32'(ens));
      chk("model_ew", 32'(bus.o_ew_light), 32'(eew));
      chk("model_tick", 32'(bus.o_tick), 32'(m_tick));
      chk("model_ack", 32'(bus.o_ped_ack), 32'(m_ack));
      if (bus.o_state != 3'd6)
         chk("allred_guard", 32'(bus.o_ns_light[2] | bus.o_ew_light[2]), 32'd1);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   function automatic vec_t mk(input bit r, input bit e, input bit f, input bit p, input int n,
                               input int st, input int rem, input logic [2:0] ns,
                               input logic [2:0] ew, input bit tk, input bit ak);
      vec_t v;
      v.rst = r; v.en = e; v.fl = f; v.ped = p; v.n = n;
      v.st = st; v.rem = rem; v.ns = ns; v.ew = ew; v.tk = tk; v.ak = ak;
      return v;
   endfunction

   vec_t tab[$];

   initial begin
      int prev_st, last_k, nticks;
      int dwell[$];
      int seq[$];
      int exp_dwell[6] = '{60, 20, 10, 60, 20, 10};
      int exp_seq[6]   = '{1, 2, 3, 4, 5, 0};
      bit fl;

      bus.i_en = 1'b0; bus.i_flash = 1'b0; bus.i_ped_req = 1'b0;

      //                rst en fl pd  n   st rem  ns      ew      tk ak
      tab.push_back(mk(1, 0, 0, 0,  1, 0, 6, 3'b001, 3'b100, 0, 0));
      tab.push_back(mk(0, 1, 0, 0,  9, 0, 6, 3'b001, 3'b100, 0, 0));
      tab.push_back(mk(0, 1, 0, 0,  1, 0, 5, 3'b001, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 1,  1, 0, 2, 3'b001, 3'b100, 0, 1));
      tab.push_back(mk(0, 1, 0, 0,  1, 0, 2, 3'b001, 3'b100, 0, 0));
      tab.push_back(mk(0, 1, 0, 0,  8, 0, 1, 3'b001, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 1,  1, 0, 1, 3'b001, 3'b100, 0, 1));
      tab.push_back(mk(0, 1, 0, 0,  9, 1, 2, 3'b010, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 1,  1, 1, 2, 3'b010, 3'b100, 0, 0));
      tab.push_back(mk(0, 0, 0, 0, 35, 1, 2, 3'b010, 3'b100, 0, 0));
      tab.push_back(mk(0, 1, 0, 0,  9, 1, 1, 3'b010, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 10, 2, 1, 3'b100, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 10, 3, 6, 3'b100, 3'b001, 1, 0));
      tab.push_back(mk(0, 1, 1, 0,  1, 6, 0, 3'b010, 3'b010, 0, 0));
      tab.push_back(mk(0, 1, 1, 0,  9, 6, 0, 3'b000, 3'b000, 1, 0));
      tab.push_back(mk(0, 1, 1, 0, 10, 6, 0, 3'b010, 3'b010, 1, 0));
      tab.push_back(mk(0, 1, 0, 0,  1, 5, 1, 3'b100, 3'b100, 0, 0));
      tab.push_back(mk(0, 1, 0, 0,  9, 0, 6, 3'b001, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 20, 0, 4, 3'b001, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 0,  9, 0, 4, 3'b001, 3'b100, 0, 0));
      tab.push_back(mk(0, 1, 0, 1,  1, 0, 2, 3'b001, 3'b100, 1, 1));
      tab.push_back(mk(0, 1, 0, 0, 10, 0, 1, 3'b001, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 10, 1, 2, 3'b010, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 20, 2, 1, 3'b100, 3'b100, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 10, 3, 6, 3'b100, 3'b001, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 60, 4, 2, 3'b100, 3'b010, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 10, 4, 1, 3'b100, 3'b010, 1, 0));
      tab.push_back(mk(1, 1, 0, 0,  1, 0, 6, 3'b001, 3'b100, 0, 0));
      tab.push_back(mk(1, 0, 1, 0,  1, 0, 6, 3'b001, 3'b100, 0, 0));
      tab.push_back(mk(0, 1, 0, 0, 10, 0, 5, 3'b001, 3'b100, 1, 0));

      foreach (tab[i]) begin
         rst = tab[i].rst; bus.i_en = tab[i].en;
         bus.i_flash = tab[i].fl; bus.i_ped_req = tab[i].ped;
         repeat (tab[i].n) step();
         chk($sformatf("vec%0d_state", i), 32'(bus.o_state), 32'(tab[i].st));
         chk($sformatf("vec%0d_remain", i), 32'(bus.o_remain), 32'(tab[i].rem));
         chk($sformatf("vec%0d_bcd", i), 32'(bus.o_remain_bcd), 32'(to_bcd(tab[i].rem)));
         chk($sformatf("vec%0d_ns", i), 32'(bus.o_ns_light), 32'(tab[i].ns));
         chk($sformatf("vec%0d_ew", i), 32'(bus.o_ew_light), 32'(tab[i].ew));
         chk($sformatf("vec%0d_tick", i), 32'(bus.o_tick), 32'(tab[i].tk));
         chk($sformatf("vec%0d_ack", i), 32'(bus.o_ped_ack), 32'(tab[i].ak));
      end

      // Full-cycle dwell measurement from reset release.
      rst = 1'b1; bus.i_en = 1'b1; bus.i_flash = 1'b0; bus.i_ped_req = 1'b0;
      step();
      rst = 1'b0;
      prev_st = int'(bus.o_state);
      last_k  = 0;
      nticks  = 0;
      for (int k = 1; k <= 180; k++) begin
         step();
         if (bus.o_tick) nticks++;
         if (int'(bus.o_state) != prev_st) begin
            dwell.push_back(k - last_k);
            seq.push_back(int'(bus.o_state));
            last_k  = k;
            prev_st = int'(bus.o_state);
         end
      end
      chk("cycle_changes", 32'(dwell.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("dwell%0d", i), (i < dwell.size()) ? 32'(dwell[i]) : 32'hFFFF_FFFF,
             32'(exp_dwell[i]));
         chk($sformatf("seq%0d", i), (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF_FFFF,
             32'(exp_seq[i]));
      end
      chk("cycle_ticks", 32'(nticks), 32'd18);

      // Randomized run; the model checks every cycle.
      rst = 1'b1; step(); rst = 1'b0;
      fl = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(99) == 0) fl = !fl;
         bus.i_flash   = fl;
         bus.i_en      = ($urandom_range(9) != 0);
         bus.i_ped_req = ($urandom_range(9) == 0);
         rst           = ($urandom_range(499) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
